// File: rtl/mem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_ctrl_pkg
// Shared definitions for the data-memory access sequencer:
//   - access size codes used by the MemRead/MemWrite decoder outputs
//   - sequencer state encoding (IDLE / REQ / DONE)
//   - default bus timeout
//   - alignment helper used when ALIGN_EXC_EN is defined
// -----------------------------------------------------------------------------
package mem_ctrl_pkg;

  // Access size encoding, identical for loads and stores.
  localparam logic [1:0] SZ_NONE = 2'b00;
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  // REQ-state cycles without bus_ack before the access is aborted.
  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;

  // A half must sit on an even address, a word on a multiple of four.
  function automatic logic f_misaligned(input logic [1:0] size,
                                        input logic [1:0] addr_lo);
    logic r;
    r = 1'b0;
    if (size == SZ_HALF && addr_lo[0])       r = 1'b1;
    if (size == SZ_WORD && addr_lo != 2'b00) r = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// -----------------------------------------------------------------------------
// mem_lane_align
// Purely combinational lane steering between the core and a 32-bit
// little-endian data bus.
//   Store side: byte enables and lane-replicated write data.
//   Load side : lane extraction and sign/zero extension of bus read data.
// Ports:
//   i_size     access size (SZ_NONE/BYTE/HALF/WORD)
//   i_is_load  1 = load (extraction active), 0 = store
//   i_addr_lo  byte offset within the word, addr[1:0]
//   i_lu       1 = zero-extend load, 0 = sign-extend
//   i_wdata    store operand
//   i_rdata    raw bus read data
//   o_be       byte enables, bit i = byte lane i
//   o_wdata    replicated store data (zero for loads)
//   o_rdata    extracted and extended load data (zero for stores)
// -----------------------------------------------------------------------------
module mem_lane_align
  import mem_ctrl_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_is_load,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_lu,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [31:0] w_shift;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Move the addressed byte down to lane 0.
  assign w_shift = i_rdata >> {i_addr_lo, 3'b000};
  assign w_byte  = w_shift[7:0];
  // Halves are selected by addr[1] only; addr[0] is ignored here.
  assign w_half  = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

  // Byte enables apply to both loads and stores.
  always_comb begin
    o_be = 4'b0000;
    case (i_size)
      SZ_BYTE: o_be = 4'b0001 << i_addr_lo;
      SZ_HALF: o_be = i_addr_lo[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: o_be = 4'b1111;
      default: o_be = 4'b0000;
    endcase
  end

  // Store data is replicated so the slave can pick any enabled lane.
  always_comb begin
    o_wdata = 32'h0;
    if (!i_is_load) begin
      case (i_size)
        SZ_BYTE: o_wdata = {4{i_wdata[7:0]}};
        SZ_HALF: o_wdata = {2{i_wdata[15:0]}};
        SZ_WORD: o_wdata = i_wdata;
        default: o_wdata = 32'h0;
      endcase
    end
  end

  always_comb begin
    o_rdata = 32'h0;
    if (i_is_load) begin
      case (i_size)
        SZ_BYTE: o_rdata = i_lu ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
        SZ_HALF: o_rdata = i_lu ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
        SZ_WORD: o_rdata = i_rdata;
        default: o_rdata = 32'h0;
      endcase
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
// Multi-cycle data-memory access sequencer between the MIPS EX/MEM stage and
// a req/ack data bus. One bus transaction per load/store; the pipeline is
// stalled until the access completes or times out.
//
// Optional feature (macro ALIGN_EXC_EN): misaligned half/word accesses skip
// the bus and complete next cycle with err=1. Without the macro there is no
// alignment check and err signals a bus timeout only.
//
// Handshake: bus_req is registered and stays high, with bus_we/bus_addr/
// bus_be/bus_wdata stable, until the first cycle bus_ack is sampled high
// (bus_rdata is sampled in that same cycle) or the timeout expires. An ack
// arriving in the timeout cycle wins.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   mem_read, mem_write   load/store size codes (00 none,01 b,10 h,11 w)
//   load_unsigned         zero-extend (1) or sign-extend (0) loads
//   flush                 blocks a new access while in IDLE
//   addr, wdata           byte address and store operand
//   stall                 pipeline hold (combinational in IDLE)
//   done, err, rdata      one-cycle completion, error flag, load result
//   bus_*                 data bus request side
//   dbg_state             current sequencer state (IDLE=0, REQ=1, DONE=2)
// -----------------------------------------------------------------------------
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
)
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  mem_read,
  input  logic [1:0]  mem_write,
  input  logic        load_unsigned,
  input  logic        flush,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0]  S_IDLE = IDLE;
  localparam logic [1:0]  S_REQ  = REQ;
  localparam logic [1:0]  S_DONE = DONE;
  localparam logic [15:0] L_TMO  = 16'(TIMEOUT_CYCLES);

  // Registered state.
  logic [1:0]  r_state;
  logic [15:0] r_cnt;
  logic        r_bus_req;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [1:0]  r_size;
  logic        r_we;
  logic        r_lu;
  logic [31:0] r_rdata;
  logic        r_err;

  // Combinational helpers.
  logic        w_wr_any;
  logic        w_rd_any;
  logic        w_start;
  logic [1:0]  w_size_in;
  logic        w_misalign;
  logic [15:0] w_cnt_next;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_ld_data;

  assign w_wr_any  = |mem_write;
  assign w_rd_any  = |mem_read;
  assign w_start   = (w_wr_any | w_rd_any) & ~flush;
  // When both codes are set the store wins and the load is dropped.
  assign w_size_in = w_wr_any ? mem_write : mem_read;

`ifdef ALIGN_EXC_EN
  assign w_misalign = f_misaligned(w_size_in, addr[1:0]);
`else
  assign w_misalign = 1'b0;
`endif

  // r_cnt holds REQ cycles already spent without ack; the current cycle is
  // the TIMEOUT_CYCLES-th when r_cnt+1 reaches the limit.
  assign w_cnt_next = r_cnt + 16'd1;

  mem_lane_align u_lane (
    .i_size    (r_size),
    .i_is_load (~r_we),
    .i_addr_lo (r_addr[1:0]),
    .i_lu      (r_lu),
    .i_wdata   (r_wdata),
    .i_rdata   (bus_rdata),
    .o_be      (w_be),
    .o_wdata   (w_wdata),
    .o_rdata   (w_ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= 16'd0;
      r_bus_req <= 1'b0;
      r_addr    <= 32'h0;
      r_wdata   <= 32'h0;
      r_size    <= SZ_NONE;
      r_we      <= 1'b0;
      r_lu      <= 1'b0;
      r_rdata   <= 32'h0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_addr  <= addr;
            r_wdata <= wdata;
            r_size  <= w_size_in;
            r_we    <= w_wr_any;
            r_lu    <= load_unsigned;
            r_cnt   <= 16'd0;
            r_rdata <= 32'h0;
            if (w_misalign) begin
              // Rejected without touching the bus.
              r_err   <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_err     <= 1'b0;
              r_bus_req <= 1'b1;
              r_state   <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (bus_ack) begin
            r_rdata   <= w_ld_data;
            r_err     <= 1'b0;
            r_bus_req <= 1'b0;
            r_state   <= S_DONE;
          end else if (w_cnt_next == L_TMO) begin
            r_rdata   <= 32'h0;
            r_err     <= 1'b1;
            r_bus_req <= 1'b0;
            r_state   <= S_DONE;
          end else begin
            r_cnt <= w_cnt_next;
          end
        end
        S_DONE: begin
          // The pipeline still shows the finished request this cycle, so
          // never start from here.
          r_state <= S_IDLE;
        end
        default: begin
          r_bus_req <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  // Stall combinationally in the decode cycle so the instruction is held.
  assign stall     = ((r_state == S_IDLE) & w_start) | (r_state == S_REQ);
  assign done      = (r_state == S_DONE);
  assign err       = done & r_err;
  assign rdata     = r_rdata;
  assign bus_req   = r_bus_req;
  assign bus_we    = r_we;
  assign bus_addr  = {r_addr[31:2], 2'b00};
  assign bus_be    = w_be;
  assign bus_wdata = w_wdata;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
// Directed bench for mem_access_ctrl with TIMEOUT_CYCLES=4. Stimulus pushes
// expected bus requests and completions into queues; a monitor pops and
// compares whenever bus_req rises or done is high.
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl;

  logic        clk;
  logic        rst_n;
  logic [1:0]  mem_read;
  logic [1:0]  mem_write;
  logic        load_unsigned;
  logic        flush;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic [1:0]  dbg_state;

  localparam logic [1:0] ST_IDLE = 2'd0;

  mem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .load_unsigned (load_unsigned),
    .flush         (flush),
    .addr          (addr),
    .wdata         (wdata),
    .stall         (stall),
    .done          (done),
    .err           (err),
    .rdata         (rdata),
    .bus_req       (bus_req),
    .bus_we        (bus_we),
    .bus_addr      (bus_addr),
    .bus_be        (bus_be),
    .bus_wdata     (bus_wdata),
    .bus_ack       (bus_ack),
    .bus_rdata     (bus_rdata),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  // {err, rdata}
  logic [32:0] exp_q[$];
  // {we, addr, be, wdata}
  logic [68:0] bus_q[$];
  int ack_after = 0;   // 0 = never acknowledge
  int last_gap  = -1;  // IDLE cycles between the last two bus_req pulses

  task automatic chk(input string name, input logic [68:0] act, input logic [68:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- bus responder ----------------
  initial begin
    int req_cycles;
    bus_ack = 1'b0;
    req_cycles = 0;
    forever begin
      @(negedge clk);
      if (bus_req) begin
        req_cycles++;
        bus_ack = (ack_after != 0) && (req_cycles == ack_after);
      end else begin
        req_cycles = 0;
        bus_ack = 1'b0;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic prev_req;
    logic prev_done;
    int idle_cnt;
    logic [68:0] be_exp;
    logic [32:0] re_exp;
    prev_req = 1'b0;
    prev_done = 1'b0;
    idle_cnt = 0;
    @(posedge rst_n);
    forever begin
      @(negedge clk);
      if (bus_req && !prev_req) begin
        last_gap = idle_cnt;
        if (bus_q.size() == 0) begin
          total++; bad++;
          $display("FAIL bus_unexpected actual bus_req=1 addr=0x%0h expected no request", bus_addr);
        end else begin
          be_exp = bus_q.pop_front();
          chk("bus_we", 69'(bus_we), 69'(be_exp[68]));
          chk("bus_addr", 69'(bus_addr), 69'(be_exp[67:36]));
          chk("bus_be", 69'(bus_be), 69'(be_exp[35:32]));
          if (be_exp[68]) chk("bus_wdata", 69'(bus_wdata), 69'(be_exp[31:0]));
        end
      end
      if (bus_req) idle_cnt = 0;
      else if (dbg_state == ST_IDLE) idle_cnt++;
      if (done) begin
        chk("done_one_cycle", 69'(prev_done), 69'(0));
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL done_unexpected actual done=1 expected no completion");
        end else begin
          re_exp = exp_q.pop_front();
          chk("err", 69'(err), 69'(re_exp[32]));
          chk("rdata", 69'(rdata), 69'(re_exp[31:0]));
        end
      end
      prev_req = bus_req;
      prev_done = done;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    mem_read = 2'b00; mem_write = 2'b00; load_unsigned = 1'b0;
    flush = 1'b0; addr = 32'h0; wdata = 32'h0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    clear_inputs();
  endtask

  // Present a request from the IDLE cycle until done; inputs stay held
  // through the DONE cycle, as the pipeline would.
  task automatic access(input logic [1:0] rd, input logic [1:0] wr, input logic lu,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int ack_k, input logic [31:0] brd, input int exp_lat);
    int lat;
    bit got;
    @(negedge clk);
    mem_read = rd; mem_write = wr; load_unsigned = lu; flush = 1'b0;
    addr = a; wdata = wd; ack_after = ack_k; bus_rdata = brd;
    #1 chk("stall_request_cycle", 69'(stall), 69'(1));
    lat = 0; got = 0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (done) got = 1;
      else chk("stall_waiting", 69'(stall), 69'(1));
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL done_timeout actual no done in 40 cycles expected done at %0d", exp_lat);
    end else begin
      chk("latency", 69'(lat), 69'(exp_lat));
      chk("stall_at_done", 69'(stall), 69'(0));
      chk("bus_req_at_done", 69'(bus_req), 69'(0));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    bus_rdata = 32'h0;
    clear_inputs();
    #12;
    chk("rst_stall", 69'(stall), 69'(0));
    chk("rst_done", 69'(done), 69'(0));
    chk("rst_err", 69'(err), 69'(0));
    chk("rst_bus_req", 69'(bus_req), 69'(0));
    chk("rst_bus_we", 69'(bus_we), 69'(0));
    chk("rst_bus_addr", 69'(bus_addr), 69'(0));
    chk("rst_bus_be", 69'(bus_be), 69'(0));
    chk("rst_bus_wdata", 69'(bus_wdata), 69'(0));
    chk("rst_rdata", 69'(rdata), 69'(0));
    chk("rst_state", 69'(dbg_state), 69'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // sb to lane 3, ack after 1 cycle
    bus_q.push_back({1'b1, 32'h0000_1000, 4'b1000, 32'hA5A5_A5A5});
    exp_q.push_back({1'b0, 32'h0});
    access(2'b00, 2'b01, 1'b0, 32'h0000_1003, 32'h0000_00A5, 1, 32'h0, 2);
    idle_cycle();

    // lb signed, ack after 2 cycles
    bus_q.push_back({1'b0, 32'h0000_2000, 4'b0010, 32'h0});
    exp_q.push_back({1'b0, 32'hFFFF_FFF6});
    access(2'b01, 2'b00, 1'b0, 32'h0000_2001, 32'h0, 2, 32'h1234_F600, 3);
    idle_cycle();

    // lbu
    bus_q.push_back({1'b0, 32'h0000_2000, 4'b0010, 32'h0});
    exp_q.push_back({1'b0, 32'h0000_00F6});
    access(2'b01, 2'b00, 1'b1, 32'h0000_2001, 32'h0, 1, 32'h1234_F600, 2);
    idle_cycle();

    // lh upper half signed, ack after 3 cycles
    bus_q.push_back({1'b0, 32'h0000_2000, 4'b1100, 32'h0});
    exp_q.push_back({1'b0, 32'hFFFF_8001});
    access(2'b10, 2'b00, 1'b0, 32'h0000_2002, 32'h0, 3, 32'h8001_ABCD, 4);
    idle_cycle();

    // lhu lower half
    bus_q.push_back({1'b0, 32'h0000_2000, 4'b0011, 32'h0});
    exp_q.push_back({1'b0, 32'h0000_ABCD});
    access(2'b10, 2'b00, 1'b1, 32'h0000_2000, 32'h0, 1, 32'h8001_ABCD, 2);
    idle_cycle();

    // lw with no ack: 4 REQ cycles then err
    bus_q.push_back({1'b0, 32'h0000_4000, 4'b1111, 32'h0});
    exp_q.push_back({1'b1, 32'h0});
    access(2'b11, 2'b00, 1'b0, 32'h0000_4000, 32'h0, 0, 32'h1111_1111, 5);
    idle_cycle();

    // lw with ack on the 4th REQ cycle: ack beats timeout
    bus_q.push_back({1'b0, 32'h0000_4000, 4'b1111, 32'h0});
    exp_q.push_back({1'b0, 32'hDEAD_BEEF});
    access(2'b11, 2'b00, 1'b0, 32'h0000_4000, 32'h0, 4, 32'hDEAD_BEEF, 5);
    idle_cycle();

    // both codes set: word store performed, load ignored
    bus_q.push_back({1'b1, 32'h0000_5000, 4'b1111, 32'h1122_3344});
    exp_q.push_back({1'b0, 32'h0});
    access(2'b11, 2'b11, 1'b0, 32'h0000_5000, 32'h1122_3344, 1, 32'hFFFF_FFFF, 2);
    idle_cycle();

    // sh to upper half
    bus_q.push_back({1'b1, 32'h0000_5000, 4'b1100, 32'hBEEF_BEEF});
    exp_q.push_back({1'b0, 32'h0});
    access(2'b00, 2'b10, 1'b0, 32'h0000_5002, 32'h0000_BEEF, 1, 32'h0, 2);
    idle_cycle();

`ifdef ALIGN_EXC_EN
    // misaligned sw / lh: no bus cycle, err next cycle
    exp_q.push_back({1'b1, 32'h0});
    access(2'b00, 2'b11, 1'b0, 32'h0000_3002, 32'hCAFE_F00D, 1, 32'h0, 1);
    idle_cycle();
    exp_q.push_back({1'b1, 32'h0});
    access(2'b10, 2'b00, 1'b0, 32'h0000_3001, 32'h0, 1, 32'h8001_ABCD, 1);
    idle_cycle();
`else
    // no alignment check: word ignores addr[1:0], half ignores addr[0]
    bus_q.push_back({1'b1, 32'h0000_3000, 4'b1111, 32'hCAFE_F00D});
    exp_q.push_back({1'b0, 32'h0});
    access(2'b00, 2'b11, 1'b0, 32'h0000_3002, 32'hCAFE_F00D, 1, 32'h0, 2);
    idle_cycle();
    bus_q.push_back({1'b0, 32'h0000_3000, 4'b0011, 32'h0});
    exp_q.push_back({1'b0, 32'hFFFF_ABCD});
    access(2'b10, 2'b00, 1'b0, 32'h0000_3001, 32'h0, 1, 32'h8001_ABCD, 2);
    idle_cycle();
`endif

    // back-to-back lw then sb: one IDLE cycle between bus_req pulses
    bus_q.push_back({1'b0, 32'h0000_6000, 4'b1111, 32'h0});
    exp_q.push_back({1'b0, 32'h0BAD_CAFE});
    access(2'b11, 2'b00, 1'b0, 32'h0000_6000, 32'h0, 1, 32'h0BAD_CAFE, 2);
    bus_q.push_back({1'b1, 32'h0000_6004, 4'b0100, 32'h7E7E_7E7E});
    exp_q.push_back({1'b0, 32'h0});
    access(2'b00, 2'b01, 1'b0, 32'h0000_6006, 32'h0000_007E, 1, 32'h0, 2);
    chk("b2b_idle_gap", 69'(last_gap), 69'(1));
    idle_cycle();

    // flush in IDLE blocks the access
    @(negedge clk);
    mem_read = 2'b11; flush = 1'b1; addr = 32'h0000_8000;
    #1 chk("flush_stall", 69'(stall), 69'(0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("flush_bus_req", 69'(bus_req), 69'(0));
      chk("flush_stall_hold", 69'(stall), 69'(0));
    end
    idle_cycle();

    // reset during REQ: bus_req drops at once, no done
    bus_q.push_back({1'b0, 32'h0000_7000, 4'b1111, 32'h0});
    @(negedge clk);
    mem_read = 2'b11; addr = 32'h0000_7000; ack_after = 0;
    repeat (2) @(negedge clk);
    chk("pre_reset_bus_req", 69'(bus_req), 69'(1));
    #2 rst_n = 1'b0;
    clear_inputs();
    #1;
    chk("async_rst_bus_req", 69'(bus_req), 69'(0));
    chk("async_rst_state", 69'(dbg_state), 69'(ST_IDLE));
    chk("async_rst_done", 69'(done), 69'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_no_done", 69'(done), 69'(0));
    end

    chk("exp_q_empty", 69'(exp_q.size()), 69'(0));
    chk("bus_q_empty", 69'(bus_q.size()), 69'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
